// File: rtl/code_lock_pkg.sv
// Shared FSM state type and width helpers for the code lock sequencer.
package code_lock_pkg;

   typedef enum logic [1:0] {
      ENTER = 2'd0,
      EVAL  = 2'd1,
      OPEN  = 2'd2,
      LOCK  = 2'd3
   } state_t;

   localparam int unsigned FAIL_W = 4;

   // Width needed to hold 0..n-1, never below one bit.
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n < 32'd2) ? 32'd1 : $clog2(n);
   endfunction

endpackage

// File: rtl/code_lock_ctrl_byte_eq.sv
// 8-bit combinational equality comparator shared by every code position.
module byte_eq (
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic       z
);
   assign z = (a == b);
endmodule

// File: rtl/code_lock_ctrl.sv
// Code lock sequencer: streams entered bytes through one comparator against the stored code.
// Optional lockout timer enabled by defining LOCKOUT_TIMER_EN.
module code_lock_ctrl
   import code_lock_pkg::*;
#(
   parameter int unsigned        DEPTH       = 4,
   parameter int unsigned        MAX_FAIL    = 3,
   parameter logic [8*DEPTH-1:0] RESET_CODE  = 32'h44332211,
   parameter int unsigned        LOCK_CYCLES = 1000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   input  logic [7:0] in_byte,
   output logic       in_ready,
   input  logic       clr,
   input  logic       prog,
   input  logic       relock,
   output logic       unlock,
   output logic       fail,
   output logic       lockout,
   output logic [3:0] fail_cnt
);

   localparam int unsigned       IDX_W    = clog2_min1(DEPTH);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);
   localparam logic [FAIL_W-1:0] FAIL_MAX = FAIL_W'(MAX_FAIL);

   if (DEPTH < 2 || DEPTH > 8) begin : g_bad_depth
      $error("code_lock_ctrl: DEPTH out of range");
   end
   if (MAX_FAIL < 1 || MAX_FAIL > 15) begin : g_bad_max_fail
      $error("code_lock_ctrl: MAX_FAIL out of range");
   end
   if (LOCK_CYCLES < 1) begin : g_bad_lock_cycles
      $error("code_lock_ctrl: LOCK_CYCLES must be at least 1");
   end

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              mis_q, mis_d;
   logic [7:0]        code_q [DEPTH];
   logic [7:0]        code_d [DEPTH];
   logic [FAIL_W-1:0] fail_cnt_q, fail_cnt_d;
   logic              unlock_q, unlock_d;
   logic              fail_q, fail_d;
   logic              lockout_q, lockout_d;
   logic              eq_s, in_ready_s, xfer_s;
`ifdef LOCKOUT_TIMER_EN
   localparam int unsigned      TMR_W    = clog2_min1(LOCK_CYCLES);
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(LOCK_CYCLES - 1);
   logic [TMR_W-1:0]            tmr_q, tmr_d;
`endif

   byte_eq u_byte_eq (
      .a (in_byte),
      .b (code_q[idx_q]),
      .z (eq_s)
   );

   // Handshake: ENTER and OPEN accept bytes unless clr/relock claims the cycle.
   always_comb begin
      in_ready_s = 1'b0;
      case (state_q)
         ENTER:   in_ready_s = ~clr;
         OPEN:    in_ready_s = ~relock;
         default: in_ready_s = 1'b0;
      endcase
   end

   assign xfer_s   = in_valid & in_ready_s;
   assign in_ready = in_ready_s;

   // Next-state, code store, counters and registered output decode.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      mis_d      = mis_q;
      code_d     = code_q;
      fail_cnt_d = fail_cnt_q;
`ifdef LOCKOUT_TIMER_EN
      tmr_d      = tmr_q;
`endif
      case (state_q)
         ENTER: begin
            if (clr) begin
               idx_d = {IDX_W{1'b0}};
               mis_d = 1'b0;
            end else if (xfer_s) begin
               // Every position is compared; a mismatch never shortens the entry.
               mis_d = mis_q | ~eq_s;
               if (idx_q == LAST_IDX) begin
                  idx_d   = {IDX_W{1'b0}};
                  state_d = EVAL;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else begin
               idx_d = idx_q;
            end
         end
         EVAL: begin
            mis_d = 1'b0;
            if (!mis_q) begin
               state_d    = OPEN;
               fail_cnt_d = {FAIL_W{1'b0}};
            end else begin
               fail_cnt_d = (fail_cnt_q < FAIL_MAX) ? fail_cnt_q + 4'd1 : FAIL_MAX;
               if (fail_cnt_d == FAIL_MAX) begin
                  state_d = LOCK;
`ifdef LOCKOUT_TIMER_EN
                  tmr_d   = TMR_LOAD;
`endif
               end else begin
                  state_d = ENTER;
               end
            end
         end
         OPEN: begin
            if (relock) begin
               state_d = ENTER;
               idx_d   = {IDX_W{1'b0}};
            end else if (xfer_s && prog) begin
               code_d[idx_q] = in_byte;
               if (idx_q == LAST_IDX) begin
                  idx_d   = {IDX_W{1'b0}};
                  state_d = ENTER;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else begin
               idx_d = idx_q;
            end
         end
         LOCK: begin
`ifdef LOCKOUT_TIMER_EN
            if (tmr_q == {TMR_W{1'b0}}) begin
               state_d    = ENTER;
               fail_cnt_d = {FAIL_W{1'b0}};
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
`else
            state_d = LOCK;
`endif
         end
         default: state_d = ENTER;
      endcase
      unlock_d  = (state_d == OPEN);
      lockout_d = (state_d == LOCK);
      fail_d    = (state_d == EVAL) & mis_d;
   end

   // State and output registers; reset restores the power-on code.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ENTER;
         idx_q      <= {IDX_W{1'b0}};
         mis_q      <= 1'b0;
         fail_cnt_q <= {FAIL_W{1'b0}};
         unlock_q   <= 1'b0;
         fail_q     <= 1'b0;
         lockout_q  <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            code_q[i] <= RESET_CODE[8*i +: 8];
         end
`ifdef LOCKOUT_TIMER_EN
         tmr_q      <= {TMR_W{1'b0}};
`endif
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         mis_q      <= mis_d;
         fail_cnt_q <= fail_cnt_d;
         unlock_q   <= unlock_d;
         fail_q     <= fail_d;
         lockout_q  <= lockout_d;
         code_q     <= code_d;
`ifdef LOCKOUT_TIMER_EN
         tmr_q      <= tmr_d;
`endif
      end
   end

   assign unlock   = unlock_q;
   assign fail     = fail_q;
   assign lockout  = lockout_q;
   assign fail_cnt = fail_cnt_q;

endmodule
